// File: rtl/mem_pattern_bist_ctrl.sv
// rtl/mem_pattern_bist_ctrl.sv - pattern-decoder and test-memory BIST sequencer
// Walks six decoder patterns, writing then reading back every address, and latches the first mismatch.
module mem_pattern_bist_ctrl #(
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [2:0]        q,
   input  logic [7:0]        data_t,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [7:0]        mem_wdata,
   output logic              mem_re,
   input  logic [7:0]        mem_rdata,
   output logic              busy,
   output logic              done,
   output logic              fail,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [2:0]        fail_q
);

   typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

   localparam logic [2:0]        LAST_PAT  = 3'd5;
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
   logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
   logic [2:0]        sel_q, sel_d;
   logic [2:0]        fail_pat_q, fail_pat_d;
   logic              cmp_valid_q, cmp_valid_d;
   logic              fail_flag_q, fail_flag_d;
   logic              mismatch;

   // Case inequality so an X/Z bit in the read data counts as a failure.
   assign mismatch = cmp_valid_q && (mem_rdata !== data_t);

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      sel_d       = sel_q;
      cmp_valid_d = 1'b0;
      cmp_addr_d  = addr_q;
      fail_flag_d = fail_flag_q;
      fail_addr_d = fail_addr_q;
      fail_pat_d  = fail_pat_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d     = S_WRITE;
               addr_d      = '0;
               sel_d       = '0;
               fail_flag_d = 1'b0;
               fail_addr_d = '0;
               fail_pat_d  = '0;
            end
         end
         S_WRITE: begin
            addr_d = addr_q + ADDR_W'(1);
            if (addr_q == LAST_ADDR) state_d = S_READ;
         end
         S_READ: begin
            addr_d      = addr_q + ADDR_W'(1);
            cmp_valid_d = 1'b1;
            if (addr_q == LAST_ADDR) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            addr_d = '0;
            if (sel_q == LAST_PAT) begin
               state_d = S_DONE;
            end else begin
               sel_d   = sel_q + 3'd1;
               state_d = S_WRITE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // The read issued alongside a detected mismatch is simply abandoned.
      if (mismatch && (state_q == S_READ || state_q == S_DRAIN)) begin
         state_d     = S_DONE;
         cmp_valid_d = 1'b0;
         fail_flag_d = 1'b1;
         fail_addr_d = cmp_addr_q;
         fail_pat_d  = sel_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         sel_q       <= '0;
         cmp_valid_q <= 1'b0;
         cmp_addr_q  <= '0;
         fail_flag_q <= 1'b0;
         fail_addr_q <= '0;
         fail_pat_q  <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         sel_q       <= sel_d;
         cmp_valid_q <= cmp_valid_d;
         cmp_addr_q  <= cmp_addr_d;
         fail_flag_q <= fail_flag_d;
         fail_addr_q <= fail_addr_d;
         fail_pat_q  <= fail_pat_d;
      end
   end

   assign mem_we    = (state_q == S_WRITE);
   assign mem_re    = (state_q == S_READ);
   assign mem_addr  = (mem_we || mem_re) ? addr_q : '0;
   assign mem_wdata = mem_we ? data_t : 8'h00;
   assign busy      = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_DRAIN);
   assign done      = (state_q == S_DONE);
   assign fail      = fail_flag_q;
   assign fail_addr = fail_addr_q;
   assign fail_q    = fail_pat_q;
   assign q         = sel_q;

endmodule
